video_fetch: RTL

- Producer side of the video byte buffer: fetches BSIZE-byte words from frame memory and hands one word at a time to the buffer.
- Hands over on the buffer's data and load inputs whenever the buffer reports empty.
- Walks the frame linearly from word address 0 to FRAME_WORDS-1 and wraps to 0.
- Restarts at address 0 on every frame_rst pulse (driven from the vsync timing block).

---
 rtl/video_pkg.sv | 14 +
 rtl/video_addr_ctr.sv | 23 ++
 rtl/video_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants and fetch FSM encoding for the video fetch path
package video_pkg;
    localparam int BSIZE       = 4;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / BSIZE;
    localparam int ADDR_W      = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/video_addr_ctr.sv
// rtl/video_addr_ctr.sv - frame word address counter, wraps at FRAME_WORDS-1, clear has priority
module video_addr_ctr #(
    parameter int ADDR_W      = video_pkg::ADDR_W,
    parameter int FRAME_WORDS = video_pkg::FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
    end
endmodule

// File: rtl/video_fetch.sv
// rtl/video_fetch.sv - fetches frame words from memory and hands one word per load to the video buffer
module video_fetch #(
    parameter int BSIZE       = video_pkg::BSIZE,
    parameter int ADDR_W      = video_pkg::ADDR_W,
    parameter int FRAME_WORDS = video_pkg::FRAME_WORDS
) (
    input  logic                 clk25MHz,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 frame_rst,
    input  logic                 buf_empty,
    output logic [BSIZE*8-1:0]   data,
    output logic                 load,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [BSIZE*8-1:0]   mem_rdata,
    output logic                 underrun
);
    import video_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] addr;
    logic              ack_ok;
    logic              take;
    logic              issue;
    logic              drop;
    logic              armed;

    assign ack_ok = mem_req && mem_ack;

    video_addr_ctr #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_addr_ctr (
        .clk   (clk25MHz),
        .rst_n (rst_n),
        .inc   (take),
        .clr   (frame_rst),
        .addr  (addr)
    );

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // REQ with mem_req low means the previous answer was thrown away and a fresh request is due
    always_comb begin
        state_next = state;
        load       = 1'b0;
        take       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
                issue      = 1'b1;
            end
            REQ: begin
                if (ack_ok) begin
                    if (!drop && !frame_rst) begin
                        take       = 1'b1;
                        state_next = FULL;
                    end
                end else if (!mem_req) begin
                    issue = 1'b1;
                end
            end
            FULL: begin
                if (frame_rst) begin
                    state_next = REQ;
                    issue      = 1'b1;
                end else if (en && buf_empty && armed) begin
                    load       = 1'b1;
                    state_next = REQ;
                    issue      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            drop     <= 1'b0;
            armed    <= 1'b1;
            underrun <= 1'b0;
        end else begin
            if (take) begin
                data <= mem_rdata;
            end
            if (ack_ok) begin
                mem_req <= 1'b0;
            end else if (issue) begin
                mem_req <= 1'b1;
            end
            if (issue) begin
                mem_addr <= frame_rst ? '0 : addr;
            end
            // an outstanding request is never abandoned; its answer is dropped instead
            if (ack_ok) begin
                drop <= 1'b0;
            end else if (frame_rst && mem_req) begin
                drop <= 1'b1;
            end
            if (frame_rst || !buf_empty) begin
                armed <= 1'b1;
            end else if (load) begin
                armed <= 1'b0;
            end
            if (frame_rst) begin
                underrun <= 1'b0;
            end else if (en && buf_empty && armed && (state != FULL)) begin
                underrun <= 1'b1;
            end
        end
    end
endmodule
